// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer: operator and state encodings, flag positions.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } seq_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_operand_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce and a single press pulse per accepted rising level.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Synchroniser chain for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Any return to the accepted level restarts the count, so bouncing never accumulates.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front end for the ALU: loads A, B and operator one enter press at a time, executes and holds the result.
// Build option ALU_CHAIN_EN: enter in S_SHOW feeds the result back as operand A (accumulator chaining).
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int N            = 2,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_data,
    input  logic [1:0]   sw_op,
    input  logic         btn_enter,
    input  logic         btn_clear,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] res_q,
    output logic [3:0]   flags_q,
    output logic         res_valid,
    output logic [2:0]   state_o
);

    logic enter_s, clear_s;

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_enter (
        .clk(clk), .rst_n(rst_n), .raw(btn_enter), .press(enter_s)
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
        .clk(clk), .rst_n(rst_n), .raw(btn_clear), .press(clear_s)
    );

    seq_state_t   state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, res_r_q, res_d;
    alu_op_t      op_q, op_d;
    logic [3:0]   flags_r_q, flags_d;
    logic         valid_q, valid_d;

    // Next-state and register updates; clear overrides everything including a same-cycle enter.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_r_q;
        flags_d = flags_r_q;
        valid_d = valid_q;
        if (clear_s) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            res_d   = '0;
            flags_d = 4'b0000;
            valid_d = 1'b0;
            state_d = S_LOAD_A;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (enter_s) begin
                        a_d     = sw_data;
                        state_d = S_LOAD_B;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
                S_LOAD_B: begin
                    if (enter_s) begin
                        b_d     = sw_data;
                        state_d = S_LOAD_OP;
                    end else begin
                        state_d = S_LOAD_B;
                    end
                end
                S_LOAD_OP: begin
                    if (enter_s) begin
                        op_d    = alu_op_t'(sw_op);
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_LOAD_OP;
                    end
                end
                S_EXEC: begin
                    res_d   = alu_result;
                    flags_d = alu_flags;
                    valid_d = 1'b1;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (enter_s) begin
                        valid_d = 1'b0;
`ifdef ALU_CHAIN_EN
                        a_d     = res_r_q;
                        state_d = S_LOAD_B;
`else
                        state_d = S_LOAD_A;
`endif
                    end else begin
                        state_d = S_SHOW;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                end
            endcase
        end
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            res_r_q   <= '0;
            flags_r_q <= 4'b0000;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_r_q   <= res_d;
            flags_r_q <= flags_d;
            valid_q   <= valid_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign res_q     = res_r_q;
    assign flags_q   = flags_r_q;
    assign res_valid = valid_q;
    assign state_o   = state_q;

endmodule
